// File: rtl/mips_pkg.sv
// Shared MIPS store definitions: low three opcode bits of the store family and
// the byte-enable patterns used to steer data onto the four 8-bit bus lanes.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_SB  = 3'b000,
    OP_SH  = 3'b001,
    OP_SWL = 3'b010,
    OP_SW  = 3'b011,
    OP_SWR = 3'b110
  } store_op_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_L3   = 4'b0111;
  localparam logic [3:0] BE_U3   = 4'b1110;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Word-aligned bus address for any byte address.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_store_formatter_if.sv
// CPU store request plus Avalon-style write bus seen by the store formatter.
// slave: the formatter; master: the CPU/memory side driving requests and stalls.
interface mips_store_formatter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_data;
  logic [ADDR_W-1:0]     bus_address;
  logic                  bus_write;
  logic                  bus_waitrequest;
  logic [DATA_W-1:0]     bus_writedata;
  logic [DATA_W/8-1:0]   bus_byteenable;
  logic                  done;
  logic                  err;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, bus_waitrequest,
    output req_ready, bus_address, bus_write, bus_writedata, bus_byteenable,
           done, err
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, bus_waitrequest,
    input  req_ready, bus_address, bus_write, bus_writedata, bus_byteenable,
           done, err
  );
endinterface

// File: rtl/mips_store_lane_mux.sv
// Combinational lane steering for SB/SH/SW/SWL/SWR: byte enables, shifted write
// data, and a reject flag for misaligned halfword/word stores or unknown opcodes.
module mips_store_lane_mux
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rt,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    be         = BE_NONE;
    wdata      = '0;
    misaligned = 1'b0;
    case (op)
      OP_SB: begin
        be    = BE_B0 << offset;
        wdata = {4{rt[7:0]}};
      end
      OP_SH: begin
        wdata = {2{rt[15:0]}};
        case (offset)
          2'd0:    be = BE_H0;
          2'd2:    be = BE_H1;
          default: misaligned = 1'b1;
        endcase
      end
      OP_SW: begin
        wdata = rt;
        if (offset == 2'd0) be = BE_W;
        else                misaligned = 1'b1;
      end
      // SWL writes the upper bytes of rt into the low lanes up to the offset.
      OP_SWL: begin
        case (offset)
          2'd0: begin be = BE_B0; wdata = {24'h0, rt[31:24]}; end
          2'd1: begin be = BE_H0; wdata = {16'h0, rt[31:16]}; end
          2'd2: begin be = BE_L3; wdata = {8'h0,  rt[31:8]};  end
          default: begin be = BE_W; wdata = rt; end
        endcase
      end
      // SWR writes the lower bytes of rt into the lanes from the offset upward.
      OP_SWR: begin
        case (offset)
          2'd0: begin be = BE_W;  wdata = rt; end
          2'd1: begin be = BE_U3; wdata = {rt[23:0], 8'h0};  end
          2'd2: begin be = BE_H1; wdata = {rt[15:0], 16'h0}; end
          default: begin be = BE_B3; wdata = {rt[7:0], 24'h0}; end
        endcase
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_store_formatter.sv
// Store formatter: accepts one CPU store, issues a single byte-enabled bus write
// (held through waitrequest), then pulses done, or done+err for rejected requests.
module mips_store_formatter
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  mips_store_formatter_if.slave sif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;

  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              lane_bad;

  mips_store_lane_mux u_lane_mux (
    .op         (sif.req_op),
    .offset     (sif.req_addr[1:0]),
    .rt         (sif.req_data),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .misaligned (lane_bad)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= BE_NONE;
    end else begin
      case (state)
        // Accept: rejected requests leave the bus registers untouched.
        S_IDLE: begin
          if (sif.req_valid) begin
            if (lane_bad) begin
              state <= S_RESP;
              err_q <= 1'b1;
            end else begin
              state   <= S_WRITE;
              err_q   <= 1'b0;
              addr_q  <= {sif.req_addr[ADDR_W-1:2], 2'b00};
              wdata_q <= lane_wdata;
              be_q    <= lane_be;
            end
          end
        end
        S_WRITE: begin
          if (!sif.bus_waitrequest) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sif.req_ready      = (state == S_IDLE);
  assign sif.bus_write      = (state == S_WRITE);
  assign sif.bus_address    = addr_q;
  assign sif.bus_writedata  = wdata_q;
  assign sif.bus_byteenable = be_q;
  assign sif.done           = (state == S_RESP);
  assign sif.err            = (state == S_RESP) & err_q;

endmodule
